ibex_pext_simd_seq: RTL and testbench
=====================================

// Module: ibex_pext_simd_seq
// PURPOSE
// - Multi-cycle packed-SIMD add/sub/shift engine for the Zpn path, generalising the per-op width/sign/sub/cross/sat/round decode into one parametrised unit.
// - Processes one element per cycle over a DataWidth-bit operand pair with a runtime element width, so one narrow datapath serves all of 8/16/32/64.
// - Sits beside the ALU and is driven by the ID/EX stage through a valid/ready handshake.
// - Result returns through a valid/ready handshake.
// - Sticky saturation flag feeds the vxsat CSR.
// PARAMETERS
// - DataWidth  32  operand/result width; 32 or 64.
// - EwDefault  1   element-width code applied when ew_i is illegal for DataWidth (1 = 16-bit).
// PORTS
// - clk_i         in   1          clock.
// - rst_ni        in   1          asynchronous active-low reset.
// - in_valid_i    in   1          operation request.
// - in_ready_o    out  1          unit can accept (IDLE only).
// - op_i          in   3          pext_seq_op_e: ADD, SUB, CRAS, CRSA, SRA, SRL, SLL.
// - ew_i          in   2          element width: 0=8, 1=16, 2=32, 3=64.
// - signed_i      in   1          signed saturation/halving/compare semantics.
// - sat_i         in   1          saturating (K-form) result.
// - half_i        in   1          halving (R-form) add/sub; rounding for shifts.
// - op_a_i        in   DataWidth  rs1.
// - op_b_i        in   DataWidth  rs2; shifts use op_b_i[log2(ew)-1:0] as scalar shamt.
// - flush_i       in   1          abort current op.
// - out_valid_o   out  1          result available.
// - out_ready_i   in   1          consumer accepts result.
// - result_o      out  DataWidth  packed result.
// - ov_o          out  1          sticky saturation flag (vxsat).
// - ov_clr_i      in   1          clear sticky flag.
// BEHAVIOUR
// - Reset values: FSM IDLE, in_ready_o=1, out_valid_o=0, result_o=0, ov_o=0, element counter 0.
// - FSM transitions:
//   - IDLE->BUSY on in_valid_i&in_ready_o; operands, controls and shamt are latched.
//   - BUSY computes element idx per cycle into result register, idx++.
//   - BUSY->DONE after idx==N-1 (N=DataWidth/ew).
//   - DONE->IDLE on out_ready_i.
// - Latency: out_valid_o rises N cycles after the accept cycle.
// - out_valid_o holds with result_o stable until accepted; no new accept in the same cycle as a DONE handshake.
// - Illegal width: ew_i==3 with DataWidth==32 uses EwDefault.
// - ADD/SUB: element-wise in ew+1 bits.
// - CRAS: odd elem a[i]+b[i-1]; even elem a[i]-b[i+1].
// - CRSA: odd a[i]-b[i-1]; even a[i]+b[i+1].
// - CRAS/CRSA with ew==DataWidth (single element) behave as ADD.
// - sat_i: clamp to [-2^(ew-1), 2^(ew-1)-1] if signed_i, else [0, 2^ew-1]; clamp sets op-local ov.
// - half_i (add/sub): (ew+1)-bit sum >>1, arithmetic if signed_i; never sets ov.
// - sat_i and half_i both set: half_i wins.
// - SRA/SRL: shift by shamt.
//   - half_i: add bit[shamt-1] before shift (round-half-up).
//   - shamt==0 → passthrough, no rounding.
// - SLL: shift by shamt.
//   - With sat_i: signed clamp when shifted-out bits differ from the result sign, sets ov.
// - Op-local ov ORs into the sticky flag only on the DONE handshake.
// - flush_i in any state → IDLE next cycle, out_valid_o=0, op-local ov discarded, result_o unchanged.
// - ov_clr_i has priority over a same-cycle set.
// - Reset mid-op returns to reset values immediately.
// CONFIGURATION
// - IBEX_PEXT_VXSAT_EN defined: sticky ov register and ov_clr_i as above.
// - IBEX_PEXT_VXSAT_EN undefined: no flag register, ov_o tied 0, ov_clr_i ignored; sat_i still clamps results.
// STRUCTURE
// - ibex_pkg_pext gains: pext_seq_op_e (3-bit enum), pext_ew_e (2-bit enum), localparam function ew_bits(ew) returning 8/16/32/64.
// - Sub-module ibex_pext_seq_elem: combinational one-element datapath (64-bit-wide max, masked to ew).
//   - Inputs: a, b, partner-b, shamt, controls.
//   - Outputs: element result and ov.
// - Top: FSM, counter, operand/result registers, vxsat register.
// TESTING
// - ADD16 sat signed, a=0x7FFF_0001, b=0x0001_0001 -> result 0x7FFF_0002 after 2 cycles, ov_o=1 after handshake.
// - CRAS16 wrap, a=0x0005_0009, b=0x0002_0003 -> result 0x0008_0007, ov_o unchanged.
// - SUB8 halving signed, a=0x80808080, b=0x01010101 -> 0xBFBFBFBF (each (-128-1)>>1=-65); latency 4.
// - SRA16 rounding, a=0xFFFF_0005, shamt=1 -> 0x0000_0003; SLL8 sat signed, a=0x40404040, shamt=1 -> 0x7F7F7F7F, ov=1.
// - flush_i asserted in BUSY cycle 2 of an 8-bit op -> IDLE next cycle, no out_valid_o, ov_o stays 0.
// - out_ready_i low for 5 cycles -> result_o/out_valid_o stable, in_ready_o=0; rst_ni low mid-BUSY -> all outputs at reset values.

Source files
------------

// File: rtl/ibex_pkg_pext.sv
// Shared types and helpers for the sequential packed-SIMD add/sub/shift unit.
// Provides the operation and element-width enums, the FSM state type and small
// functions used to decode element widths and extend element operands.
package ibex_pkg_pext;

  typedef enum logic [2:0] {
    PEXT_ADD  = 3'd0,
    PEXT_SUB  = 3'd1,
    PEXT_CRAS = 3'd2,
    PEXT_CRSA = 3'd3,
    PEXT_SRA  = 3'd4,
    PEXT_SRL  = 3'd5,
    PEXT_SLL  = 3'd6
  } pext_seq_op_e;

  typedef enum logic [1:0] {
    PEXT_EW8  = 2'd0,
    PEXT_EW16 = 2'd1,
    PEXT_EW32 = 2'd2,
    PEXT_EW64 = 2'd3
  } pext_ew_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_BUSY = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  // Element width code -> number of bits.
  function automatic logic [6:0] ew_bits(input logic [1:0] ew);
    logic [6:0] w;
    case (pext_ew_e'(ew))
      PEXT_EW8:  w = 7'd8;
      PEXT_EW16: w = 7'd16;
      PEXT_EW32: w = 7'd32;
      PEXT_EW64: w = 7'd64;
      default:   w = 7'd16;
    endcase
    return w;
  endfunction

  // Low w bits set.
  function automatic logic [63:0] ew_mask(input logic [6:0] w);
    logic [63:0] m;
    if (w == 7'd64) begin
      m = {64{1'b1}};
    end else begin
      m = (64'd1 << w) - 64'd1;
    end
    return m;
  endfunction

  // Extend the low w bits of x to 66 bits, sign- or zero-filled.
  function automatic logic signed [65:0] ext66(input logic [63:0] x, input logic [6:0] w,
                                               input logic sgn);
    logic [5:0]  msb;
    logic        sb;
    logic [65:0] r;
    msb = 6'(w - 7'd1);
    sb  = sgn & x[msb];
    for (int i = 0; i < 64; i++) begin
      r[i] = (i < int'(w)) ? x[i] : sb;
    end
    r[65:64] = {sb, sb};
    return $signed(r);
  endfunction

endpackage

// File: rtl/ibex_pext_seq_elem.sv
// One-element combinational datapath of the sequential packed-SIMD unit.
// Ports:
//   op_i, ew_i            operation and element width code
//   signed_i/sat_i/half_i signedness, saturation, halving/rounding controls
//   odd_i, single_i       element index is odd / operand holds a single element
//   a_i, b_i, pb_i        element operands in the low ew bits (pb_i = partner b for CRAS/CRSA)
//   shamt_i               scalar shift amount (already masked to ew)
//   res_o, ov_o           element result (low ew bits, upper bits zero) and saturation flag
module ibex_pext_seq_elem
  import ibex_pkg_pext::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  ew_i,
  input  logic        signed_i,
  input  logic        sat_i,
  input  logic        half_i,
  input  logic        odd_i,
  input  logic        single_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [63:0] pb_i,
  input  logic [5:0]  shamt_i,
  output logic [63:0] res_o,
  output logic        ov_o
);

  pext_seq_op_e       op_s;
  logic [6:0]         w_s;
  logic [5:0]         msb_s;
  logic [63:0]        mask_s, sl_s;
  logic signed [65:0] ea_s, ex_s, sum_s, smax_s, smin_s, umax_s, sh_s, back_s, ea_sgn_s;
  logic               sub_s, use_pb_s;
  logic               unused_s;

  assign op_s     = pext_seq_op_e'(op_i);
  assign unused_s = ^sh_s[65:64];

  // Element arithmetic: add/sub family with halving/saturation, and the three shifts
  always_comb begin
    w_s    = ew_bits(ew_i);
    msb_s  = 6'(w_s - 7'd1);
    mask_s = ew_mask(w_s);
    smax_s = (66'sd1 <<< (w_s - 7'd1)) - 66'sd1;
    smin_s = -(66'sd1 <<< (w_s - 7'd1));
    umax_s = (66'sd1 <<< w_s) - 66'sd1;

    // Cross forms pick the partner element and alternate add/sub by index parity;
    // with a single element there is no partner so they degrade to ADD.
    use_pb_s = 1'b0;
    sub_s    = 1'b0;
    case (op_s)
      PEXT_SUB:  sub_s = 1'b1;
      PEXT_CRAS: begin
        use_pb_s = ~single_i;
        sub_s    = ~single_i & ~odd_i;
      end
      PEXT_CRSA: begin
        use_pb_s = ~single_i;
        sub_s    = ~single_i & odd_i;
      end
      default:   sub_s = 1'b0;
    endcase

    ea_s  = ext66(a_i, w_s, signed_i);
    ex_s  = ext66(use_pb_s ? pb_i : b_i, w_s, signed_i);
    sum_s = sub_s ? (ea_s - ex_s) : (ea_s + ex_s);

    // Right shifts; rounding adds the last bit shifted out.
    sh_s = ext66(a_i, w_s, op_s == PEXT_SRA) >>> shamt_i;
    if (half_i && (shamt_i != 6'd0)) begin
      sh_s = sh_s + $signed({65'd0, a_i[shamt_i - 6'd1]});
    end else begin
      sh_s = sh_s;
    end

    // Left shift overflows when shifting the result back does not restore the operand.
    sl_s     = (a_i << shamt_i) & mask_s;
    back_s   = ext66(sl_s, w_s, 1'b1) >>> shamt_i;
    ea_sgn_s = ext66(a_i, w_s, 1'b1);

    res_o = 64'd0;
    ov_o  = 1'b0;
    case (op_s)
      PEXT_SRA, PEXT_SRL: res_o = sh_s[63:0] & mask_s;
      PEXT_SLL: begin
        if (sat_i && (back_s != ea_sgn_s)) begin
          ov_o  = 1'b1;
          res_o = (a_i[msb_s] ? smin_s[63:0] : smax_s[63:0]) & mask_s;
        end else begin
          res_o = sl_s;
        end
      end
      default: begin
        if (half_i) begin
          // Bits [ew:1] of the (ew+1)-bit sum; halving never saturates.
          res_o = sum_s[64:1] & mask_s;
        end else if (sat_i && signed_i) begin
          if (sum_s > smax_s) begin
            res_o = smax_s[63:0] & mask_s;
            ov_o  = 1'b1;
          end else if (sum_s < smin_s) begin
            res_o = smin_s[63:0] & mask_s;
            ov_o  = 1'b1;
          end else begin
            res_o = sum_s[63:0] & mask_s;
          end
        end else if (sat_i) begin
          if (sum_s < 66'sd0) begin
            res_o = 64'd0;
            ov_o  = 1'b1;
          end else if (sum_s > umax_s) begin
            res_o = mask_s;
            ov_o  = 1'b1;
          end else begin
            res_o = sum_s[63:0] & mask_s;
          end
        end else begin
          res_o = sum_s[63:0] & mask_s;
        end
      end
    endcase
  end

endmodule

// File: rtl/ibex_pext_simd_seq.sv
// Sequential packed-SIMD add/sub/shift engine: one element per cycle.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   in_valid_i / in_ready_o       request handshake (ready only in IDLE)
//   op_i, ew_i, signed_i, sat_i, half_i, op_a_i, op_b_i   operation and operands
//   flush_i                       abort the current operation
//   out_valid_o / out_ready_i     result handshake; result_o is the packed result
//   ov_o, ov_clr_i                sticky saturation flag (vxsat) and its clear
// Build option: define IBEX_PEXT_VXSAT_EN to include the sticky flag register;
// otherwise ov_o is tied low and ov_clr_i is ignored (results still clamp).
module ibex_pext_simd_seq
  import ibex_pkg_pext::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned EwDefault = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2:0]           op_i,
  input  logic [1:0]           ew_i,
  input  logic                 signed_i,
  input  logic                 sat_i,
  input  logic                 half_i,
  input  logic [DataWidth-1:0] op_a_i,
  input  logic [DataWidth-1:0] op_b_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] result_o,
  output logic                 ov_o,
  input  logic                 ov_clr_i
);

  seq_state_e           state_q, state_d;
  logic [2:0]           idx_q, idx_d, op_q, op_d;
  logic [1:0]           ew_q, ew_d;
  logic [DataWidth-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic                 sgn_q, sgn_d, sat_q, sat_d, half_q, half_d, ovl_q, ovl_d;
  logic [5:0]           shamt_q, shamt_d;

  logic [1:0]  ew_in_s;
  logic [6:0]  w_in_s, w_q_s;
  logic [2:0]  last_idx_s;
  logic        single_s, elem_ov_s, done_hs_s, unused_s;
  logic [8:0]  off_s, poff_s;
  logic [63:0] mask_s, a64_s, b64_s, elem_res_s, acc64_s;

  // A 64-bit element request on a 32-bit datapath falls back to the default width.
  assign ew_in_s   = ((ew_i == 2'd3) && (DataWidth == 32)) ? 2'(EwDefault) : ew_i;
  assign w_in_s    = ew_bits(ew_in_s);
  assign done_hs_s = (state_q == SEQ_DONE) & out_ready_i & ~flush_i;
  assign unused_s  = ^{op_b_i, acc64_s};

  // Element selection and accumulator merge for the current index
  always_comb begin
    w_q_s      = ew_bits(ew_q);
    mask_s     = ew_mask(w_q_s);
    last_idx_s = 3'((DataWidth / 32'(w_q_s)) - 32'd1);
    single_s   = (32'(w_q_s) == DataWidth);
    off_s      = {6'd0, idx_q} * {2'd0, w_q_s};
    poff_s     = {6'd0, idx_q ^ 3'd1} * {2'd0, w_q_s};
    a64_s      = 64'(a_q);
    b64_s      = 64'(b_q);
    acc64_s    = (64'(acc_q) & ~(mask_s << off_s)) | (elem_res_s << off_s);
  end

  ibex_pext_seq_elem u_elem (
    .op_i     (op_q),
    .ew_i     (ew_q),
    .signed_i (sgn_q),
    .sat_i    (sat_q),
    .half_i   (half_q),
    .odd_i    (idx_q[0]),
    .single_i (single_s),
    .a_i      (a64_s >> off_s),
    .b_i      (b64_s >> off_s),
    .pb_i     (b64_s >> poff_s),
    .shamt_i  (shamt_q),
    .res_o    (elem_res_s),
    .ov_o     (elem_ov_s)
  );

  // FSM next state and register updates
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    ew_d     = ew_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    sat_d    = sat_q;
    half_d   = half_q;
    shamt_d  = shamt_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovl_d    = ovl_q;
    if (flush_i) begin
      // Abort: drop progress and op-local ov, keep the last delivered result.
      state_d = SEQ_IDLE;
      idx_d   = 3'd0;
      ovl_d   = 1'b0;
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          if (in_valid_i) begin
            state_d = SEQ_BUSY;
            idx_d   = 3'd0;
            op_d    = op_i;
            ew_d    = ew_in_s;
            a_d     = op_a_i;
            b_d     = op_b_i;
            sgn_d   = signed_i;
            sat_d   = sat_i;
            half_d  = half_i;
            shamt_d = op_b_i[5:0] & 6'(w_in_s - 7'd1);
            acc_d   = '0;
            ovl_d   = 1'b0;
          end else begin
            state_d = SEQ_IDLE;
          end
        end
        SEQ_BUSY: begin
          acc_d = acc64_s[DataWidth-1:0];
          ovl_d = ovl_q | elem_ov_s;
          if (idx_q == last_idx_s) begin
            // Result register only changes here, so it stays stable through DONE and flushes.
            state_d  = SEQ_DONE;
            idx_d    = 3'd0;
            result_d = acc64_s[DataWidth-1:0];
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        SEQ_DONE: begin
          if (out_ready_i) begin
            state_d = SEQ_IDLE;
          end else begin
            state_d = SEQ_DONE;
          end
        end
        default: state_d = SEQ_IDLE;
      endcase
    end
  end

  // State, operand, accumulator and result registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= SEQ_IDLE;
      idx_q    <= 3'd0;
      op_q     <= 3'd0;
      ew_q     <= 2'd0;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      sat_q    <= 1'b0;
      half_q   <= 1'b0;
      shamt_q  <= 6'd0;
      acc_q    <= '0;
      result_q <= '0;
      ovl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      ew_q     <= ew_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      sat_q    <= sat_d;
      half_q   <= half_d;
      shamt_q  <= shamt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovl_q    <= ovl_d;
    end
  end

  assign in_ready_o  = (state_q == SEQ_IDLE);
  assign out_valid_o = (state_q == SEQ_DONE);
  assign result_o    = result_q;

`ifdef IBEX_PEXT_VXSAT_EN
  logic ov_q, ov_d;

  // Sticky vxsat: clear beats a same-cycle set; only delivered results contribute
  always_comb begin
    if (ov_clr_i) begin
      ov_d = 1'b0;
    end else if (done_hs_s) begin
      ov_d = ov_q | ovl_q;
    end else begin
      ov_d = ov_q;
    end
  end

  // Sticky vxsat register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ov_q <= 1'b0;
    end else begin
      ov_q <= ov_d;
    end
  end

  assign ov_o = ov_q;
`else
  logic unused_vxsat_s;
  assign unused_vxsat_s = ^{ov_clr_i, ovl_q, done_hs_s};
  assign ov_o           = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_pext_simd_seq.sv
// Self-checking bench for ibex_pext_simd_seq (DataWidth = 32): directed cases
// plus randomized operations compared against an arithmetic reference model.
module tb_ibex_pext_simd_seq;

`ifdef IBEX_PEXT_VXSAT_EN
  localparam bit VXSAT = 1'b1;
`else
  localparam bit VXSAT = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  op_i = 3'd0;
  logic [1:0]  ew_i = 2'd0;
  logic        signed_i = 1'b0;
  logic        sat_i = 1'b0;
  logic        half_i = 1'b0;
  logic [31:0] op_a_i = 32'd0;
  logic [31:0] op_b_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] result_o;
  logic        ov_o;
  logic        ov_clr_i = 1'b0;

  int          n_vec = 0;
  int          n_bad = 0;
  bit          sticky = 1'b0;
  logic [31:0] last_res = 32'd0;

  ibex_pext_simd_seq #(.DataWidth(32), .EwDefault(1)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .ew_i        (ew_i),
    .signed_i    (signed_i),
    .sat_i       (sat_i),
    .half_i      (half_i),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .ov_o        (ov_o),
    .ov_clr_i    (ov_clr_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_ov();
    return VXSAT ? sticky : 1'b0;
  endfunction

  // Element i of x as an integer of width w, signed or unsigned.
  function automatic longint field(input logic [31:0] x, input int i, input int w, input bit sgn);
    longint f;
    f = (longint'(x) >> (i * w)) & ((longint'(1) << w) - 1);
    if (sgn && f >= (longint'(1) << (w - 1))) f = f - (longint'(1) << w);
    return f;
  endfunction

  // Reference: the mathematical result of each element, then reduced mod 2^w.
  function automatic void ref_op(input int op, input int ewc, input bit sgn, input bit sat,
                                 input bit half, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output bit ov, output int n);
    int w, sh;
    longint m, av, bv, pv, s, v, lo, hi;
    logic [63:0] acc;
    w   = (ewc == 3) ? 16 : (8 << ewc);
    n   = 32 / w;
    sh  = int'(b % 32'(w));
    m   = (longint'(1) << w) - 1;
    acc = 64'd0;
    ov  = 1'b0;
    for (int i = 0; i < n; i++) begin
      av = field(a, i, w, sgn);
      bv = field(b, i, w, sgn);
      pv = (n == 1) ? 0 : field(b, (i % 2 == 1) ? i - 1 : i + 1, w, sgn);
      s  = 0;
      v  = 0;
      case (op)
        0: s = av + bv;
        1: s = av - bv;
        2: s = (n == 1) ? av + bv : ((i % 2 == 1) ? av + pv : av - pv);
        3: s = (n == 1) ? av + bv : ((i % 2 == 1) ? av - pv : av + pv);
        default: s = 0;
      endcase
      if (op <= 3) begin
        lo = sgn ? -(longint'(1) << (w - 1)) : 0;
        hi = sgn ? (longint'(1) << (w - 1)) - 1 : m;
        if (half) v = s >>> 1;
        else if (sat && s > hi) begin v = hi; ov = 1'b1; end
        else if (sat && s < lo) begin v = lo; ov = 1'b1; end
        else v = s;
      end else if (op == 4 || op == 5) begin
        v = field(a, i, w, op == 4);
        if (half && sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
        else v = v >>> sh;
      end else begin
        v  = field(a, i, w, 1'b1) * (longint'(1) << sh);
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
        if (sat && v > hi) begin v = hi; ov = 1'b1; end
        else if (sat && v < lo) begin v = lo; ov = 1'b1; end
      end
      acc = acc | (64'(v & m) << (i * w));
    end
    r = acc[31:0];
  endfunction

  task automatic drive_req(input int op, input int ewc, input bit sgn, input bit sat,
                           input bit half, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    in_valid_i = 1'b1;
    op_i       = 3'(op);
    ew_i       = 2'(ewc);
    signed_i   = sgn;
    sat_i      = sat;
    half_i     = half;
    op_a_i     = a;
    op_b_i     = b;
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  task automatic run_op(input string tag, input int op, input int ewc, input bit sgn,
                        input bit sat, input bit half, input logic [31:0] a,
                        input logic [31:0] b, input int stall, input bit clr_hs);
    logic [31:0] er;
    bit          eov;
    int          n, lat;
    ref_op(op, ewc, sgn, sat, half, a, b, er, eov, n);
    drive_req(op, ewc, sgn, sat, half, a, b);
    lat = 0;
    while (!out_valid_o && lat < 64) begin
      @(negedge clk_i);
      lat++;
    end
    check_val({tag, " latency"}, 64'(lat), 64'(n));
    check_val({tag, " result"}, 64'(result_o), 64'(er));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk_i);
      check_val($sformatf("%s stall%0d valid/ready", tag, k), {62'd0, out_valid_o, in_ready_o}, 64'd2);
      check_val($sformatf("%s stall%0d result", tag, k), 64'(result_o), 64'(er));
    end
    out_ready_i = 1'b1;
    ov_clr_i    = clr_hs;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    ov_clr_i    = 1'b0;
    sticky      = clr_hs ? 1'b0 : (sticky | eov);
    last_res    = er;
    check_val({tag, " ov"}, 64'(ov_o), 64'(exp_ov()));
    check_val({tag, " idle"}, {62'd0, out_valid_o, in_ready_o}, 64'd1);
  endtask

  task automatic clear_ov();
    @(negedge clk_i);
    ov_clr_i = 1'b1;
    @(negedge clk_i);
    ov_clr_i = 1'b0;
    sticky   = 1'b0;
    check_val("ov clear", 64'(ov_o), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    check_val("reset in_ready", 64'(in_ready_o), 64'd1);
    check_val("reset out_valid", 64'(out_valid_o), 64'd0);
    check_val("reset result", 64'(result_o), 64'd0);
    check_val("reset ov", 64'(ov_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_val("post-reset idle", {62'd0, out_valid_o, in_ready_o}, 64'd1);

    // Directed cases
    run_op("add16 sat",   0, 1, 1'b1, 1'b1, 1'b0, 32'h7FFF_0001, 32'h0001_0001, 0, 1'b0);
    run_op("cras16 wrap", 2, 1, 1'b0, 1'b0, 1'b0, 32'h0005_0009, 32'h0002_0003, 0, 1'b0);
    run_op("sub8 half",   1, 0, 1'b1, 1'b0, 1'b1, 32'h8080_8080, 32'h0101_0101, 0, 1'b0);
    run_op("sra16 round", 4, 1, 1'b1, 1'b0, 1'b1, 32'hFFFF_0005, 32'h0000_0001, 0, 1'b0);
    run_op("sll8 sat",    6, 0, 1'b1, 1'b1, 1'b0, 32'h4040_4040, 32'h0000_0001, 0, 1'b0);
    run_op("ew64 fold",   0, 3, 1'b0, 1'b0, 1'b0, 32'hFFFF_0001, 32'h0001_FFFF, 0, 1'b0);
    run_op("cras32 single", 2, 2, 1'b0, 1'b0, 1'b0, 32'h1000_0000, 32'h0000_0005, 0, 1'b0);
    run_op("sub8u sat",   1, 0, 1'b0, 1'b1, 1'b0, 32'h0010_FF05, 32'h0020_0106, 0, 1'b0);
    run_op("srl32 sh0",   5, 2, 1'b0, 1'b0, 1'b1, 32'h8000_0003, 32'h0000_0020, 0, 1'b0);
    run_op("stall add8",  0, 0, 1'b0, 1'b0, 1'b0, 32'h1122_3344, 32'h0101_0101, 5, 1'b0);
    run_op("clr wins",    0, 0, 1'b1, 1'b1, 1'b0, 32'h7F7F_7F7F, 32'h0101_0101, 0, 1'b1);

    // Flush during the second BUSY cycle of an 8-bit saturating op
    clear_ov();
    drive_req(0, 0, 1'b1, 1'b1, 1'b0, 32'h7F7F_7F7F, 32'h0101_0101);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check_val("flush idle", {62'd0, out_valid_o, in_ready_o}, 64'd1);
    check_val("flush result kept", 64'(result_o), 64'(last_res));
    repeat (5) @(negedge clk_i);
    check_val("flush no valid", 64'(out_valid_o), 64'd0);
    check_val("flush ov", 64'(ov_o), 64'(exp_ov()));

    // Randomized operations
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 7) == 0) clear_ov();
      run_op($sformatf("rand%0d", t), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
             int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
    end

    // Reset in the middle of a BUSY sequence
    drive_req(1, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0101_0101);
    rst_ni = 1'b0;
    #1;
    check_val("midreset ready/valid", {62'd0, out_valid_o, in_ready_o}, 64'd1);
    check_val("midreset result", 64'(result_o), 64'd0);
    check_val("midreset ov", 64'(ov_o), 64'd0);
    @(negedge clk_i);
    rst_ni   = 1'b1;
    sticky   = 1'b0;
    last_res = 32'd0;
    run_op("after reset", 3, 1, 1'b1, 1'b1, 1'b0, 32'h8000_7FFF, 32'h0001_0001, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
